// File: rtl/chacha_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chacha_pin_ctrl
// Brief    : Pin-side responder for the byte-serial ChaCha host protocol.
//            Synchronizes the host strobe, decodes key/nonce/start/read
//            commands, holds the cipher input state, and buffers the
//            keystream block returned by the core for byte-wise readout.
// Revision : 1.0 - initial release
// ============================================================================
module chacha_pin_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [7:0]   din,
  input  logic [1:0]   cmd,
  input  logic         stb,
  output logic [7:0]   dout,
  output logic         busy,
  output logic         ready,
  output logic [255:0] key_o,
  output logic [95:0]  nonce_o,
  output logic [31:0]  counter_o,
  output logic         start_o,
  input  logic         done_i,
  input  logic [511:0] block_i
);

  // A synchronizer shorter than two flops offers no metastability margin,
  // so the chain length is clamped to at least two.
  localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] c_CMD_KEY   = 2'b00;
  localparam logic [1:0] c_CMD_NONCE = 2'b01;
  localparam logic [1:0] c_CMD_START = 2'b10;
  localparam logic [1:0] c_CMD_READ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [c_STAGES-1:0] r_sync;
  logic            r_stb_prev;
  logic            w_stb_rise;
  logic            w_fire;
  logic            w_accept;

  logic [255:0]    r_key;
  logic [95:0]     r_nonce;
  logic [31:0]     r_counter;
  logic [511:0]    r_buf;
  logic [7:0]      r_dout;
  logic            r_start;
  logic [4:0]      r_kp;
  logic [3:0]      r_ncp;
  logic [5:0]      r_rp;
  logic [3:0]      w_nbyte;

  // Host strobe synchronizer plus delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_stb_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[c_STAGES-2:0], stb};
      r_stb_prev <= r_sync[c_STAGES-1];
    end
  end

  // The previous-value flop keeps tracking while ena is low, so raising
  // ena with stb already high does not manufacture a spurious edge.
  assign w_stb_rise = r_sync[c_STAGES-1] & ~r_stb_prev;
  assign w_fire     = w_stb_rise & ena;
  // Commands execute only outside BUSY; edges seen in BUSY are dropped.
  assign w_accept   = w_fire & (r_state != ST_BUSY);
  assign w_nbyte    = r_ncp - 4'd4;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: start enters BUSY, core done moves to READY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_READY: begin
        if (w_accept && (cmd == c_CMD_START)) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done_i) begin
          w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command datapath: key/nonce/counter loading, start pulse, block capture
  // and read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key     <= '0;
      r_nonce   <= '0;
      r_counter <= '0;
      r_buf     <= '0;
      r_start   <= 1'b0;
      r_kp      <= '0;
      r_ncp     <= '0;
      r_rp      <= '0;
    end else begin
      r_start <= 1'b0;
      if (r_state == ST_BUSY) begin
        if (done_i) begin
          r_buf     <= block_i;
          r_counter <= r_counter + 32'd1;
          r_rp      <= '0;
        end
      end else if (w_accept) begin
        case (cmd)
          c_CMD_KEY: begin
            r_key[{r_kp, 3'b000} +: 8] <= din;
            r_kp                       <= r_kp + 5'd1;
          end
          c_CMD_NONCE: begin
            // Bytes 0-3 form the little-endian block counter, 4-15 the nonce.
            if (r_ncp < 4'd4) begin
              r_counter[{r_ncp[1:0], 3'b000} +: 8] <= din;
            end else begin
              r_nonce[{w_nbyte, 3'b000} +: 8] <= din;
            end
            r_ncp <= r_ncp + 4'd1;
          end
          c_CMD_START: begin
            r_start <= 1'b1;
            r_kp    <= '0;
            r_ncp   <= '0;
          end
          c_CMD_READ: begin
            if (r_state == ST_READY) begin
              r_rp <= r_rp + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered readout byte; follows rp/buffer one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else begin
      r_dout <= r_buf[{r_rp, 3'b000} +: 8];
    end
  end

  assign dout      = r_dout;
  assign busy      = (r_state == ST_BUSY);
  assign ready     = (r_state == ST_READY);
  assign key_o     = r_key;
  assign nonce_o   = r_nonce;
  assign counter_o = r_counter;
  assign start_o   = r_start;

endmodule
`default_nettype wire
